// File: rtl/cam_pkg.sv
// Shared definitions for the CAM request-side controller: op encodings,
// FSM state type and default geometry of the attached CAM.
package cam_pkg;

  localparam int CAM_NB_MEM    = 12;
  localparam int CAM_SIZE_ADDR = 4;
  localparam int CAM_KEY_W     = 8;
  localparam int CAM_IDX_W     = 5;

  localparam logic CAM_OP_LOOKUP = 1'b0;
  localparam logic CAM_OP_INSERT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP
  } cam_state_e;

endpackage

// File: rtl/cam_alloc.sv
// Slot allocator for cam_client: append-only write pointer, saturating
// occupancy count, per-entry valid bitmap and hit qualification of a CAM
// index against that bitmap. Only reset empties the table.
module cam_alloc
  import cam_pkg::*;
#(
  parameter int NB_MEM    = CAM_NB_MEM,
  parameter int SIZE_ADDR = CAM_SIZE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_alloc,
  input  logic [SIZE_ADDR-1:0] i_query_idx,
  output logic [SIZE_ADDR-1:0] o_ptr,
  output logic                 o_full,
  output logic                 o_query_valid
);

  localparam logic [SIZE_ADDR:0]   LP_NB_MEM = (SIZE_ADDR + 1)'(NB_MEM);
  localparam logic [SIZE_ADDR-1:0] LP_LAST   = SIZE_ADDR'(NB_MEM - 1);

  logic [SIZE_ADDR-1:0] r_ptr;
  logic [SIZE_ADDR:0]   r_count;
  logic [NB_MEM-1:0]    r_valid;

  // Claim the slot under the pointer on every granted allocation.
  always_ff @(posedge clk) begin
    // NOTE: the valid bitmap is reset, not the CAM array itself; clearing
    // these few bits is what makes every stale CAM entry invisible.
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else if (i_alloc && !o_full) begin
      r_valid[r_ptr] <= 1'b1;
      r_count        <= r_count + 1'b1;
      if (r_ptr != LP_LAST) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign o_ptr         = r_ptr;
  assign o_full        = (r_count == LP_NB_MEM);
  assign o_query_valid = ({1'b0, i_query_idx} < LP_NB_MEM) ? r_valid[i_query_idx] : 1'b0;

endmodule

// File: rtl/cam_client.sv
// Request-side controller for a 12-entry, 8-bit CAM. Accepts LOOKUP/INSERT
// requests, sequences the CAM pins, allocates slots sequentially and
// returns hit/index/full on a valid/ready response channel.
// Build option: define CAM_CLIENT_DEDUP_EN to make INSERT search first and
// return the existing index instead of writing a duplicate.
module cam_client
  import cam_pkg::*;
#(
  parameter int NB_MEM    = CAM_NB_MEM,
  parameter int SIZE_ADDR = CAM_SIZE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [7:0]           req_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [SIZE_ADDR:0]   rsp_idx,
  output logic                 rsp_full,
  output logic                 cam_enable,
  output logic                 cam_write,
  output logic [SIZE_ADDR:0]   cam_addr,
  output logic [7:0]           cam_data,
  input  logic [SIZE_ADDR:0]   cam_out,
  input  logic                 cam_found
);

  localparam logic [SIZE_ADDR:0] LP_NB_MEM = (SIZE_ADDR + 1)'(NB_MEM);

  cam_state_e r_state;
  cam_state_e w_next_state;

  logic                 r_op;
  logic [7:0]           r_key;
  logic                 r_rsp_hit;
  logic [SIZE_ADDR:0]   r_rsp_idx;
  logic                 r_rsp_full;

  logic                 w_rsp_load;
  logic                 w_rsp_hit_d;
  logic [SIZE_ADDR:0]   w_rsp_idx_d;
  logic                 w_rsp_full_d;
  logic                 w_alloc;
  logic [SIZE_ADDR-1:0] w_ptr;
  logic                 w_full;
  logic                 w_valid_at;
  logic                 w_hit;
  logic                 w_accept;

  cam_alloc #(
    .NB_MEM    (NB_MEM),
    .SIZE_ADDR (SIZE_ADDR)
  ) u_alloc (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_alloc       (w_alloc),
    .i_query_idx   (cam_out[SIZE_ADDR-1:0]),
    .o_ptr         (w_ptr),
    .o_full        (w_full),
    .o_query_valid (w_valid_at)
  );

  // Ready is held low while reset is asserted so every output reads 0.
  assign req_ready = (r_state == ST_IDLE) && rst_n;
  assign w_accept  = req_valid && req_ready;
  assign w_hit     = cam_found && (cam_out < LP_NB_MEM) && w_valid_at;

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_hit   = r_rsp_hit;
  assign rsp_idx   = r_rsp_idx;
  assign rsp_full  = r_rsp_full;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, CAM pin drive and response-load decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_rsp_load   = 1'b0;
    w_rsp_hit_d  = 1'b0;
    w_rsp_idx_d  = '0;
    w_rsp_full_d = 1'b0;
    w_alloc      = 1'b0;
    cam_enable   = 1'b0;
    cam_write    = 1'b0;
    cam_addr     = '0;
    cam_data     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef CAM_CLIENT_DEDUP_EN
          w_next_state = ST_LOOKUP;
`else
          if (req_op == CAM_OP_INSERT) begin
            if (w_full) begin
              w_next_state = ST_RESP;
              w_rsp_load   = 1'b1;
              w_rsp_full_d = 1'b1;
            end else begin
              w_next_state = ST_WRITE;
            end
          end else begin
            w_next_state = ST_LOOKUP;
          end
`endif
        end
      end
      ST_LOOKUP: begin
        cam_enable   = 1'b1;
        cam_data     = r_key;
        w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if ((r_op == CAM_OP_LOOKUP) || w_hit) begin
          w_next_state = ST_RESP;
          w_rsp_load   = 1'b1;
          w_rsp_hit_d  = w_hit;
          w_rsp_idx_d  = w_hit ? {1'b0, cam_out[SIZE_ADDR-1:0]} : '0;
        end else if (w_full) begin
          w_next_state = ST_RESP;
          w_rsp_load   = 1'b1;
          w_rsp_full_d = 1'b1;
        end else begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cam_write    = 1'b1;
        cam_addr     = {1'b0, w_ptr};
        cam_data     = r_key;
        w_alloc      = 1'b1;
        w_next_state = ST_RESP;
        w_rsp_load   = 1'b1;
        w_rsp_idx_d  = {1'b0, w_ptr};
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Latch the accepted request; these are always written before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op  <= req_op;
      r_key <= req_key;
    end
  end

  // Response registers: loaded on entry to RESP, cleared on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_hit  <= 1'b0;
      r_rsp_idx  <= '0;
      r_rsp_full <= 1'b0;
    end else if (w_rsp_load) begin
      r_rsp_hit  <= w_rsp_hit_d;
      r_rsp_idx  <= w_rsp_idx_d;
      r_rsp_full <= w_rsp_full_d;
    end else if (rsp_valid && rsp_ready) begin
      r_rsp_hit  <= 1'b0;
      r_rsp_idx  <= '0;
      r_rsp_full <= 1'b0;
    end
  end

endmodule
